// File: rtl/server_rx_checker.sv
// server_rx_checker
// Receive-side checker for the server traffic generator. It parses 64-bit AXI-Stream frames,
// checks the header and frame length, and measures one-way latency from the TX timestamp
// carried in payload beat 2.
//
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_time_stamp        local free-running time, same domain as the transmitter
//   rx_axis_*           AXI-Stream RX slave (tready is tied high)
//   o_pkt_done          one-cycle pulse, one cycle after a frame's terminating beat
//   o_pkt_ok/o_err_code status of the last finished frame
//   o_src_mac           source MAC of the last finished frame
//   o_*_latency         last/max/min latency of error-free frames
//   o_pkt_cnt/o_err_cnt saturating good/bad frame counters
module server_rx_checker #(
   parameter logic [47:0] P_MY_PORT_MAC = 48'h8D_BC_5C_4A_00_01,
   parameter logic [31:0] P_MAC_HEAD    = 32'h8D_BC_5C_4A,
   parameter int unsigned P_PKT_LEN     = 128
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [63:0] i_time_stamp,
   input  logic        rx_axis_tvalid,
   input  logic [63:0] rx_axis_tdata,
   input  logic        rx_axis_tlast,
   input  logic [7:0]  rx_axis_tkeep,
   input  logic        rx_axis_tuser,
   output logic        rx_axis_tready,
   output logic        o_pkt_done,
   output logic        o_pkt_ok,
   output logic [4:0]  o_err_code,
   output logic [47:0] o_src_mac,
   output logic [63:0] o_last_latency,
   output logic [63:0] o_max_latency,
   output logic [63:0] o_min_latency,
   output logic [31:0] o_pkt_cnt,
   output logic [15:0] o_err_cnt
);

   localparam int unsigned    BeatW    = 16;
   localparam logic [BeatW-1:0] LastBeat = BeatW'(P_PKT_LEN - 1);

   typedef enum logic [1:0] {StHdr0, StHdr1, StPayload, StDrop} state_e;

   state_e             state_q, state_d;
   logic [BeatW-1:0]   beat_q, beat_d;
   logic [4:0]         err_q, err_d;
   logic [47:0]        src_q, src_d;
   logic [63:0]        prev_ts_q, prev_ts_d;
   logic [63:0]        lat_q, lat_d;
   logic               done_q, done_d;
   logic               ok_q, ok_d;
   logic [4:0]         err_code_q, err_code_d;
   logic [47:0]        src_mac_q, src_mac_d;
   logic [63:0]        last_lat_q, last_lat_d;
   logic [63:0]        max_lat_q, max_lat_d;
   logic [63:0]        min_lat_q, min_lat_d;
   logic [31:0]        pkt_cnt_q, pkt_cnt_d;
   logic [15:0]        err_cnt_q, err_cnt_d;
   logic [4:0]         err_new, err_all;

   assign rx_axis_tready = 1'b1;

   always_comb begin
      state_d    = state_q;
      beat_d     = beat_q;
      err_d      = err_q;
      src_d      = src_q;
      prev_ts_d  = prev_ts_q;
      lat_d      = lat_q;
      done_d     = 1'b0;
      ok_d       = ok_q;
      err_code_d = err_code_q;
      src_mac_d  = src_mac_q;
      last_lat_d = last_lat_q;
      max_lat_d  = max_lat_q;
      min_lat_d  = min_lat_q;
      pkt_cnt_d  = pkt_cnt_q;
      err_cnt_d  = err_cnt_q;
      err_new    = '0;
      err_all    = err_q;

      if (rx_axis_tvalid) begin
         err_new[3] = rx_axis_tuser || (rx_axis_tkeep != 8'hFF);
         // Saturate so an endless drop cannot wrap back onto LastBeat.
         beat_d     = (beat_q == '1) ? beat_q : beat_q + 1'b1;

         unique case (state_q)
            StHdr0: begin
               err_new[0] = (rx_axis_tdata[63:16] != P_MY_PORT_MAC);
               src_d      = {rx_axis_tdata[15:0], 32'h0};
               state_d    = StHdr1;
            end
            StHdr1: begin
               src_d[31:0] = rx_axis_tdata[63:32];
               err_new[1]  = (rx_axis_tdata[31:16] != 16'h0800) ||
                             ({src_q[47:32], rx_axis_tdata[63:48]} != P_MAC_HEAD);
               state_d     = StPayload;
            end
            StPayload: begin
               // Beat 2 is the first payload beat: it carries the latency stamp and has no
               // predecessor to compare against.
               if (beat_q == BeatW'(2)) begin
                  lat_d = i_time_stamp - rx_axis_tdata;
               end else if (rx_axis_tdata < prev_ts_q) begin
                  err_new[4] = 1'b1;
               end
               prev_ts_d = rx_axis_tdata;
            end
            StDrop: begin
            end
            default: state_d = StHdr0;
         endcase

         if (rx_axis_tlast) begin
            if (beat_q != LastBeat) err_new[2] = 1'b1;
         end else if ((beat_q == LastBeat) && (state_q != StDrop)) begin
            err_new[2] = 1'b1;
            state_d    = StDrop;
         end

         err_all = err_q | err_new;
         err_d   = err_all;

         if (rx_axis_tlast) begin
            state_d    = StHdr0;
            beat_d     = '0;
            err_d      = '0;
            done_d     = 1'b1;
            err_code_d = err_all;
            ok_d       = (err_all == '0);
            src_mac_d  = src_d;
            if (err_all == '0) begin
               last_lat_d = lat_d;
               if (lat_d > max_lat_q) max_lat_d = lat_d;
               if (lat_d < min_lat_q) min_lat_d = lat_d;
               if (pkt_cnt_q != '1) pkt_cnt_d = pkt_cnt_q + 1'b1;
            end else begin
               if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= StHdr0;
         beat_q     <= '0;
         err_q      <= '0;
         src_q      <= '0;
         prev_ts_q  <= '0;
         lat_q      <= '0;
         done_q     <= 1'b0;
         ok_q       <= 1'b0;
         err_code_q <= '0;
         src_mac_q  <= '0;
         last_lat_q <= '0;
         max_lat_q  <= '0;
         min_lat_q  <= '1;
         pkt_cnt_q  <= '0;
         err_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         beat_q     <= beat_d;
         err_q      <= err_d;
         src_q      <= src_d;
         prev_ts_q  <= prev_ts_d;
         lat_q      <= lat_d;
         done_q     <= done_d;
         ok_q       <= ok_d;
         err_code_q <= err_code_d;
         src_mac_q  <= src_mac_d;
         last_lat_q <= last_lat_d;
         max_lat_q  <= max_lat_d;
         min_lat_q  <= min_lat_d;
         pkt_cnt_q  <= pkt_cnt_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign o_pkt_done     = done_q;
   assign o_pkt_ok       = ok_q;
   assign o_err_code     = err_code_q;
   assign o_src_mac      = src_mac_q;
   assign o_last_latency = last_lat_q;
   assign o_max_latency  = max_lat_q;
   assign o_min_latency  = min_lat_q;
   assign o_pkt_cnt      = pkt_cnt_q;
   assign o_err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_server_rx_checker.sv
// Directed bench for server_rx_checker: header/length/tuser/timestamp errors, latency
// tracking, back-to-back and gapped traffic, reset at reset and mid-frame.
module tb_server_rx_checker;

   localparam logic [47:0] MyMac  = 48'h8DBC5C4A0001;
   localparam logic [47:0] GoodSrc = 48'h8DBC5C4A0201;
   localparam logic [63:0] AllOnes = 64'hFFFF_FFFF_FFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [63:0] time_stamp = '0;
   logic        tvalid = 1'b0;
   logic [63:0] tdata = '0;
   logic        tlast = 1'b0;
   logic [7:0]  tkeep = 8'hFF;
   logic        tuser = 1'b0;
   logic        tready;
   logic        pkt_done;
   logic        pkt_ok;
   logic [4:0]  err_code;
   logic [47:0] src_mac;
   logic [63:0] last_lat, max_lat, min_lat;
   logic [31:0] pkt_cnt;
   logic [15:0] err_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   int done_cnt = 0;

   server_rx_checker dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_time_stamp   (time_stamp),
      .rx_axis_tvalid (tvalid),
      .rx_axis_tdata  (tdata),
      .rx_axis_tlast  (tlast),
      .rx_axis_tkeep  (tkeep),
      .rx_axis_tuser  (tuser),
      .rx_axis_tready (tready),
      .o_pkt_done     (pkt_done),
      .o_pkt_ok       (pkt_ok),
      .o_err_code     (err_code),
      .o_src_mac      (src_mac),
      .o_last_latency (last_lat),
      .o_max_latency  (max_lat),
      .o_min_latency  (min_lat),
      .o_pkt_cnt      (pkt_cnt),
      .o_err_cnt      (err_cnt)
   );

   always #5 clk = ~clk;

   // Count cycles in which the done pulse is high, sampled mid-cycle.
   always @(negedge clk) if (pkt_done === 1'b1) done_cnt++;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] beat_data(input int b, input logic [47:0] dest,
                                             input logic [47:0] src, input logic [63:0] b2_ts,
                                             input int bad_ts_at);
      if (b == 0) return {dest, src[47:32]};
      if (b == 1) return {src[31:0], 16'h0800, 16'h0000};
      if (b == bad_ts_at) return b2_ts - 64'd1;
      return b2_ts + 64'(b - 2);
   endfunction

   task automatic send_beat(input logic [63:0] d, input logic last, input logic user);
      @(negedge clk);
      tvalid = 1'b1;
      tdata  = d;
      tlast  = last;
      tuser  = user;
      @(posedge clk);
      #1;
      tvalid = 1'b0;
      tlast  = 1'b0;
      tuser  = 1'b0;
   endtask

   // Sends len beats with tlast on the final one; leaves the bench #1 after the last edge.
   task automatic send_frame(input logic [47:0] dest, input logic [47:0] src,
                             input logic [63:0] b2_ts, input logic [63:0] now, input int len,
                             input int tuser_at, input int bad_ts_at, input bit gaps);
      time_stamp = now;
      for (int b = 0; b < len; b++) begin
         if (gaps) repeat ($urandom_range(0, 2)) @(posedge clk);
         send_beat(beat_data(b, dest, src, b2_ts, bad_ts_at), b == len - 1, b == tuser_at);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_done"}, 64'(pkt_done), 64'd0);
      chk({tag, "_ok"}, 64'(pkt_ok), 64'd0);
      chk({tag, "_err"}, 64'(err_code), 64'd0);
      chk({tag, "_src"}, 64'(src_mac), 64'd0);
      chk({tag, "_last"}, last_lat, 64'd0);
      chk({tag, "_max"}, max_lat, 64'd0);
      chk({tag, "_min"}, min_lat, AllOnes);
      chk({tag, "_pkt_cnt"}, 64'(pkt_cnt), 64'd0);
      chk({tag, "_err_cnt"}, 64'(err_cnt), 64'd0);
   endtask

   initial begin
      int d0;
      void'($urandom(7));
      idle(3);
      @(negedge clk);
      rst = 1'b0;
      idle(2);
      chk_reset_outputs("rst");
      chk("tready", 64'(tready), 64'd1);

      // Good frame, latency 1050-1000.
      send_frame(MyMac, GoodSrc, 64'd1000, 64'd1050, 128, -1, -1, 1'b0);
      chk("good_done", 64'(pkt_done), 64'd1);
      chk("good_ok", 64'(pkt_ok), 64'd1);
      chk("good_err", 64'(err_code), 64'd0);
      chk("good_last", last_lat, 64'd50);
      chk("good_max", max_lat, 64'd50);
      chk("good_min", min_lat, 64'd50);
      chk("good_pkt_cnt", 64'(pkt_cnt), 64'd1);
      chk("good_src", 64'(src_mac), 64'h8DBC5C4A0201);
      idle(1);
      chk("good_done_1cyc", 64'(pkt_done), 64'd0);
      chk("good_ok_hold", 64'(pkt_ok), 64'd1);

      // Wrong destination MAC.
      send_frame(48'h8DBC5C4A0002, GoodSrc, 64'd3000, 64'd3500, 128, -1, -1, 1'b0);
      chk("dest_err", 64'(err_code), 64'h01);
      chk("dest_ok", 64'(pkt_ok), 64'd0);
      chk("dest_err_cnt", 64'(err_cnt), 64'd1);
      chk("dest_pkt_cnt", 64'(pkt_cnt), 64'd1);
      chk("dest_last", last_lat, 64'd50);
      chk("dest_max", max_lat, 64'd50);
      idle(1);

      // Short frame: tlast at beat 64.
      d0 = done_cnt;
      send_frame(MyMac, GoodSrc, 64'd1000, 64'd1050, 65, -1, -1, 1'b0);
      chk("short_done", 64'(pkt_done), 64'd1);
      chk("short_err", 64'(err_code), 64'h04);
      chk("short_err_cnt", 64'(err_cnt), 64'd2);
      idle(1);
      chk("short_pulses", 64'(done_cnt - d0), 64'd1);

      // Long frame: no tlast at 127, tlast at 130; only one done pulse, after beat 130.
      d0 = done_cnt;
      send_frame(MyMac, GoodSrc, 64'd1000, 64'd1050, 131, -1, -1, 1'b0);
      chk("long_done", 64'(pkt_done), 64'd1);
      chk("long_err", 64'(err_code), 64'h04);
      chk("long_err_cnt", 64'(err_cnt), 64'd3);
      idle(1);
      chk("long_pulses", 64'(done_cnt - d0), 64'd1);

      // tuser on beat 50.
      send_frame(MyMac, GoodSrc, 64'd1000, 64'd1050, 128, 50, -1, 1'b0);
      chk("tuser_err", 64'(err_code), 64'h08);
      chk("tuser_err_cnt", 64'(err_cnt), 64'd4);
      idle(1);

      // Timestamp 2000 then 1999.
      send_frame(MyMac, GoodSrc, 64'd2000, 64'd2100, 128, -1, 3, 1'b0);
      chk("ts_err", 64'(err_code), 64'h10);
      chk("ts_err_cnt", 64'(err_cnt), 64'd5);
      chk("ts_last", last_lat, 64'd50);
      chk("ts_min", min_lat, 64'd50);
      idle(1);

      // Single-beat frame ends straight from the first header state.
      send_frame(MyMac, GoodSrc, 64'd0, 64'd0, 1, -1, -1, 1'b0);
      chk("single_done", 64'(pkt_done), 64'd1);
      chk("single_err", 64'(err_code), 64'h04);
      chk("single_err_cnt", 64'(err_cnt), 64'd6);
      idle(1);

      // Three good frames back-to-back.
      d0 = done_cnt;
      send_frame(MyMac, GoodSrc, 64'd5000, 64'd5040, 128, -1, -1, 1'b0);
      send_frame(MyMac, GoodSrc, 64'd7000, 64'd7090, 128, -1, -1, 1'b0);
      send_frame(MyMac, GoodSrc, 64'd9000, 64'd9010, 128, -1, -1, 1'b0);
      idle(1);
      chk("b2b_pulses", 64'(done_cnt - d0), 64'd3);
      chk("b2b_max", max_lat, 64'd90);
      chk("b2b_min", min_lat, 64'd10);
      chk("b2b_last", last_lat, 64'd10);
      chk("b2b_pkt_cnt", 64'(pkt_cnt), 64'd4);
      chk("b2b_err_cnt", 64'(err_cnt), 64'd6);

      // Same three frames from reset, with random gaps.
      pulse_reset();
      idle(1);
      d0 = done_cnt;
      send_frame(MyMac, GoodSrc, 64'd5000, 64'd5040, 128, -1, -1, 1'b1);
      send_frame(MyMac, GoodSrc, 64'd7000, 64'd7090, 128, -1, -1, 1'b1);
      send_frame(MyMac, GoodSrc, 64'd9000, 64'd9010, 128, -1, -1, 1'b1);
      idle(1);
      chk("gap_pulses", 64'(done_cnt - d0), 64'd3);
      chk("gap_max", max_lat, 64'd90);
      chk("gap_min", min_lat, 64'd10);
      chk("gap_last", last_lat, 64'd10);
      chk("gap_pkt_cnt", 64'(pkt_cnt), 64'd3);
      chk("gap_err_cnt", 64'(err_cnt), 64'd0);

      // Reset asserted together with beat 30.
      d0 = done_cnt;
      time_stamp = 64'd1050;
      for (int b = 0; b < 30; b++) send_beat(beat_data(b, MyMac, GoodSrc, 64'd1000, -1), 1'b0,
                                             1'b0);
      @(negedge clk);
      tvalid = 1'b1;
      tdata  = beat_data(30, MyMac, GoodSrc, 64'd1000, -1);
      rst    = 1'b1;
      @(posedge clk);
      #1;
      tvalid = 1'b0;
      chk_reset_outputs("midrst");
      @(negedge clk);
      rst = 1'b0;
      idle(2);
      chk("midrst_pulses", 64'(done_cnt - d0), 64'd0);

      // Following good frame counts normally.
      send_frame(MyMac, GoodSrc, 64'd1000, 64'd1050, 128, -1, -1, 1'b0);
      chk("post_ok", 64'(pkt_ok), 64'd1);
      chk("post_pkt_cnt", 64'(pkt_cnt), 64'd1);
      chk("post_last", last_lat, 64'd50);
      chk("post_err_cnt", 64'(err_cnt), 64'd0);
      idle(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
